data_bus_node: RTL and testbench

DATA_BUS_NODE -- requirements
Module: data_bus_node

---
 rtl/data_bus_pkg.sv | 27 ++
 rtl/data_bus_rx_fifo.sv | 47 ++++
 rtl/data_bus_node.sv | 157 +++++++++++++++
 tb/tb_data_bus_node.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_bus_pkg.sv
// Shared definitions for the data_bus_node slice: FSM states, header field layout, opcodes.
package data_bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CTRL_HDR = 3'd1,
      ST_WAIT     = 3'd2,
      ST_OWN      = 3'd3,
      ST_LISTEN   = 3'd4,
      ST_SKIP     = 3'd5
   } state_e;

   // Header beat: opcode in the low bits, then src ID, then dst ID.
   localparam int HDR_OPC_LSB = 0;
   localparam int HDR_OPC_W   = 2;
   localparam int HDR_SRC_LSB = HDR_OPC_LSB + HDR_OPC_W;

   localparam logic [HDR_OPC_W-1:0] OP_DATA  = 2'd0;
   localparam logic [HDR_OPC_W-1:0] OP_READ  = 2'd1;
   localparam logic [HDR_OPC_W-1:0] OP_WRITE = 2'd2;
   localparam logic [HDR_OPC_W-1:0] OP_CTRL  = 2'd3;

   function automatic int hdr_dst_lsb(input int id_w);
      return HDR_SRC_LSB + id_w;
   endfunction

endpackage

// File: rtl/data_bus_rx_fifo.sv
// Receive FIFO for data_bus_node: first-word-fall-through, full refuses pushes.
module data_bus_rx_fifo #(
   parameter int WIDTH = 9,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic             do_push, do_pop;

   assign full_o  = cnt_q == (AW+1)'(DEPTH);
   assign empty_o = cnt_q == '0;
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   // Head is masked while empty so the receive data port reads zero.
   assign rdata_o = empty_o ? '0 : mem_q[rd_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + AW'(1);
         if (do_pop)  rd_q <= rd_q + AW'(1);
         if (do_push && !do_pop)      cnt_q <= cnt_q + (AW+1)'(1);
         else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end

endmodule

// File: rtl/data_bus_node.sv
// Shared-bus node: controller header issue, source grant wait, ownership and RX capture.
// Optional DATA_BUS_NODE_PARITY_EN adds even parity on the bus with a sticky error flag.
module data_bus_node
   import data_bus_pkg::*;
#(
   parameter int              DATA_W   = 8,
   parameter int              ID_W     = 2,
   parameter int              RX_DEPTH = 4,
   parameter int              WAIT_CYC = 3,
   parameter logic [ID_W-1:0] CTRL_ID  = '1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ID_W-1:0]   node_id,
   input  logic              send_valid,
   input  logic [DATA_W-1:0] send_data,
   input  logic              send_last,
   output logic              send_ready,
   output logic              recv_valid,
   output logic [DATA_W-1:0] recv_data,
   output logic              recv_last,
   input  logic              recv_ready,
   output logic [DATA_W-1:0] bus_data_o,
   output logic              bus_valid_o,
   output logic              bus_last_o,
   input  logic [DATA_W-1:0] bus_data_i,
   input  logic              bus_valid_i,
   input  logic              bus_last_i,
   output logic              bus_ready_o,
   input  logic              bus_ready_i
`ifdef DATA_BUS_NODE_PARITY_EN
   ,
   output logic              bus_par_o,
   input  logic              bus_par_i,
   output logic              par_err
`endif
);

   localparam int DST_LSB = hdr_dst_lsb(ID_W);
   localparam int CW      = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;

   if (DATA_W < 2*ID_W + 2) begin : g_bad_width
      $error("data_bus_node: DATA_W too narrow to hold opcode, src and dst");
   end

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [ID_W-1:0] src_q, src_d, dst_q, dst_d;
   logic [ID_W-1:0] hdr_src, hdr_dst;
   logic            is_ctrl, xfer, hdr_phase, hdr_hit, addressed;
   logic            drive_hdr, own, drive, push, full, empty;
   logic [DATA_W:0] head;

   assign is_ctrl   = node_id == CTRL_ID;
   assign xfer      = bus_valid_i && bus_ready_i;
   assign hdr_src   = bus_data_i[HDR_SRC_LSB +: ID_W];
   assign hdr_dst   = bus_data_i[DST_LSB +: ID_W];
   assign hdr_phase = (state_q == ST_IDLE) || (state_q == ST_CTRL_HDR);
   assign hdr_hit   = bus_valid_i && (hdr_src == node_id || hdr_dst == node_id || is_ctrl);
   assign addressed = hdr_phase ? hdr_hit
                    : (state_q != ST_SKIP) && (src_q == node_id || dst_q == node_id || is_ctrl);

   // rst_n gates the controller header path so nothing reaches the bus during reset.
   assign drive_hdr   = rst_n && hdr_phase && is_ctrl && send_valid;
   assign own         = state_q == ST_OWN;
   assign drive       = drive_hdr || own;
   assign bus_data_o  = drive ? send_data : '0;
   assign bus_valid_o = drive && send_valid;
   assign bus_last_o  = drive && send_last;
   assign send_ready  = drive && bus_ready_i;
   assign bus_ready_o = addressed ? !full : 1'b1;
   assign push        = xfer && addressed;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      src_d   = src_q;
      dst_d   = dst_q;
      case (state_q)
         ST_IDLE, ST_CTRL_HDR: begin
            if (xfer) begin
               src_d = hdr_src;
               dst_d = hdr_dst;
               cnt_d = '0;
               if (hdr_src == node_id)                 state_d = ST_WAIT;
               else if (hdr_dst == node_id || is_ctrl) state_d = ST_LISTEN;
               else                                    state_d = ST_SKIP;
            end else begin
               state_d = drive_hdr ? ST_CTRL_HDR : ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (!xfer) begin
               if (cnt_q == CW'(WAIT_CYC - 1)) begin
                  state_d = ST_OWN;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: ;
      endcase
      // A closing beat ends the packet for every node, header-only packets included.
      if (xfer && bus_last_i) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         src_d   = '1;
         dst_d   = '1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         src_q   <= '1;
         dst_q   <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         src_q   <= src_d;
         dst_q   <= dst_d;
      end
   end

   data_bus_rx_fifo #(
      .WIDTH(DATA_W + 1),
      .DEPTH(RX_DEPTH)
   ) u_rx_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push),
      .wdata_i({bus_last_i, bus_data_i}),
      .pop_i  (recv_valid && recv_ready),
      .rdata_o(head),
      .full_o (full),
      .empty_o(empty)
   );

   assign recv_valid = !empty;
   assign recv_last  = head[DATA_W];
   assign recv_data  = head[DATA_W-1:0];

`ifdef DATA_BUS_NODE_PARITY_EN
   logic par_err_q;

   assign bus_par_o = ^bus_data_o;
   assign par_err   = par_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                   par_err_q <= 1'b0;
      else if (push && ((^bus_data_i) != bus_par_i)) par_err_q <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_data_bus_node.sv
// Four-node bus bench: node 3 is the controller; bus wires are OR/AND-combined here.
module tb_data_bus_node;
   import data_bus_pkg::*;

   localparam int N  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]         sv, sl, sr, rv, rl, rr, bvo, blo, bro;
   logic [N-1:0][DW-1:0] sd, rd, bdo;
   logic [DW-1:0]        bdi;
   logic                 bvi, bli, bri;

   assign bdi = bdo[0] | bdo[1] | bdo[2] | bdo[3];
   assign bvi = |bvo;
   assign bli = |blo;
   assign bri = &bro;

`ifdef DATA_BUS_NODE_PARITY_EN
   logic [N-1:0] bpo, pe;
   logic         bpi;
   logic         par_flip = 1'b0;
   assign bpi = (|bpo) ^ par_flip;
`endif

   for (genvar g = 0; g < N; g++) begin : g_node
      data_bus_node #(.DATA_W(DW), .ID_W(2), .RX_DEPTH(4), .WAIT_CYC(3)) u_node (
         .clk        (clk),
         .rst_n      (rst_n),
         .node_id    (2'(g)),
         .send_valid (sv[g]),
         .send_data  (sd[g]),
         .send_last  (sl[g]),
         .send_ready (sr[g]),
         .recv_valid (rv[g]),
         .recv_data  (rd[g]),
         .recv_last  (rl[g]),
         .recv_ready (rr[g]),
         .bus_data_o (bdo[g]),
         .bus_valid_o(bvo[g]),
         .bus_last_o (blo[g]),
         .bus_data_i (bdi),
         .bus_valid_i(bvi),
         .bus_last_i (bli),
         .bus_ready_o(bro[g]),
         .bus_ready_i(bri)
`ifdef DATA_BUS_NODE_PARITY_EN
         ,
         .bus_par_o  (bpo[g]),
         .bus_par_i  (bpi),
         .par_err    (pe[g])
`endif
      );
   end

   int checks = 0;
   int errors = 0;
   int rcnt[N];
   int bus_xfers = 0;
   logic [DW:0] log2[$];

   always @(posedge clk) begin
      if (bvi && bri) bus_xfers++;
      for (int i = 0; i < N; i++) if (rv[i] && rr[i]) rcnt[i]++;
      if (rv[2] && rr[2]) log2.push_back({rl[2], rd[2]});
   end

   function automatic logic all_idle();
      return g_node[0].u_node.state_q == ST_IDLE && g_node[1].u_node.state_q == ST_IDLE &&
             g_node[2].u_node.state_q == ST_IDLE && g_node[3].u_node.state_q == ST_IDLE;
   endfunction

   task automatic send_beat(input int n, input logic [DW-1:0] d, input logic l, output int waited);
      bit ok;
      ok = 0;
      waited = 0;
      sd[n] = d; sl[n] = l; sv[n] = 1'b1;
      for (int c = 0; c < 64 && !ok; c++) begin
         @(negedge clk);
         waited++;
         if (sr[n]) ok = 1;
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL handshake node %0d data %h: no send_ready within 64 cycles", n, d);
      end else begin
         @(posedge clk); #1;
      end
      sv[n] = 1'b0; sl[n] = 1'b0;
   endtask

   task automatic test_reset();
      sv[3] = 1'b1; sd[3] = 8'h24;
      repeat (2) @(negedge clk);
      checks++;
      if (sr !== 4'h0 || bvo !== 4'h0 || blo !== 4'h0 || bdi !== 8'h00) begin
         errors++;
         $display("FAIL reset_bus: sr=%b bvo=%b blo=%b bdi=%h expected all zero", sr, bvo, blo, bdi);
      end
      checks++;
      if (rv !== 4'h0 || rl !== 4'h0 || rd !== 32'h0 || bro !== 4'hF) begin
         errors++;
         $display("FAIL reset_rx: rv=%b rl=%b rd=%h bro=%b expected 0,0,0,1111", rv, rl, rd, bro);
      end
      checks++;
      if (!all_idle() || g_node[1].u_node.cnt_q !== '0) begin
         errors++;
         $display("FAIL reset_state: node1 state=%0d cnt=%0d expected IDLE,0",
                  g_node[1].u_node.state_q, g_node[1].u_node.cnt_q);
      end
      sv[3] = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rv !== 4'h0 || bvo !== 4'h0 || bro !== 4'hF) begin
         errors++;
         $display("FAIL post_reset: rv=%b bvo=%b bro=%b expected 0000,0000,1111", rv, bvo, bro);
      end
   endtask

   task automatic test_basic();
      int w, b2, b0, b3;
      logic [DW:0] exp_log[3];
      exp_log = '{{1'b0, 8'h24}, {1'b0, 8'hA1}, {1'b1, 8'hA2}};
      b0 = rcnt[0]; b2 = rcnt[2]; b3 = rcnt[3];
      @(posedge clk); #1;
      sv[1] = 1'b1; sd[1] = 8'hA1;
      send_beat(3, 8'h24, 1'b0, w);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (g_node[1].u_node.state_q !== ST_WAIT || bvo[1] !== 1'b0 || sr[1] !== 1'b0) begin
            errors++;
            $display("FAIL wait_cycle%0d: state=%0d bvo=%b sr=%b expected WAIT,0,0",
                     k, g_node[1].u_node.state_q, bvo[1], sr[1]);
         end
      end
      send_beat(1, 8'hA1, 1'b0, w);
      checks++;
      if (w !== 1) begin
         errors++;
         $display("FAIL own_latency: first data handshake after %0d extra cycles, expected 1", w);
      end
      send_beat(1, 8'hA2, 1'b1, w);
      checks++;
      if (w !== 1) begin
         errors++;
         $display("FAIL back_to_back: second beat waited %0d, expected 1", w);
      end
      @(negedge clk);
      checks++;
      if (!all_idle()) begin
         errors++;
         $display("FAIL basic_idle: node1 state=%0d node2 state=%0d expected IDLE",
                  g_node[1].u_node.state_q, g_node[2].u_node.state_q);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (rcnt[2] - b2 !== 3 || rcnt[3] - b3 !== 3 || rcnt[0] - b0 !== 0) begin
         errors++;
         $display("FAIL basic_counts: n0=%0d n2=%0d n3=%0d expected 0,3,3",
                  rcnt[0] - b0, rcnt[2] - b2, rcnt[3] - b3);
      end
      for (int k = 0; k < 3; k++) begin
         checks++;
         if (log2.size() < b2 + 3 || log2[b2 + k] !== exp_log[k]) begin
            errors++;
            $display("FAIL basic_beat%0d: got %h expected %h", k,
                     (log2.size() > b2 + k) ? log2[b2 + k] : 9'h0, exp_log[k]);
         end
      end
   endtask

   task automatic test_backpressure();
      int w, b2, bx;
      @(posedge clk); #1;
      rr[2] = 1'b0;
      b2 = rcnt[2];
      bx = bus_xfers;
      send_beat(3, 8'h24, 1'b0, w);
      fork
         begin
            for (int k = 0; k < 6; k++) send_beat(1, DW'(8'hB0 + k), k == 5, w);
         end
         begin
            repeat (12) @(negedge clk);
            checks++;
            if (bri !== 1'b0 || sr[1] !== 1'b0 || bus_xfers - bx !== 4 || rv[2] !== 1'b1) begin
               errors++;
               $display("FAIL bp_stall: bri=%b sr1=%b xfers=%0d rv2=%b expected 0,0,4,1",
                        bri, sr[1], bus_xfers - bx, rv[2]);
            end
            rr[2] = 1'b1;
         end
      join
      repeat (8) @(negedge clk);
      checks++;
      if (rcnt[2] - b2 !== 7 || !all_idle()) begin
         errors++;
         $display("FAIL bp_count: node2 got %0d beats expected 7 (all_idle=%b)", rcnt[2] - b2, all_idle());
      end
      for (int k = 0; k < 7; k++) begin
         logic [DW:0] e;
         e = (k == 0) ? {1'b0, 8'h24} : {k == 6, DW'(8'hB0 + k - 1)};
         checks++;
         if (log2.size() < b2 + 7 || log2[b2 + k] !== e) begin
            errors++;
            $display("FAIL bp_beat%0d: got %h expected %h", k,
                     (log2.size() > b2 + k) ? log2[b2 + k] : 9'h0, e);
         end
      end
   endtask

   task automatic test_hdr_only();
      int w, b2;
      @(posedge clk); #1;
      b2 = rcnt[2];
      sv[1] = 1'b1; sd[1] = 8'hC5;
      send_beat(3, 8'h24, 1'b1, w);
      @(negedge clk);
      checks++;
      if (!all_idle()) begin
         errors++;
         $display("FAIL hdr_only_idle: node1 state=%0d expected IDLE", g_node[1].u_node.state_q);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (bvo[1] !== 1'b0 || g_node[1].u_node.state_q !== ST_IDLE) begin
         errors++;
         $display("FAIL hdr_only_nowait: bvo1=%b state=%0d expected 0,IDLE", bvo[1], g_node[1].u_node.state_q);
      end
      checks++;
      if (rcnt[2] - b2 !== 1 || log2.size() != b2 + 1 || log2[b2] !== {1'b1, 8'h24}) begin
         errors++;
         $display("FAIL hdr_only_rx: node2 got %0d beats expected 1 with last", rcnt[2] - b2);
      end
      sv[1] = 1'b0;
   endtask

   task automatic test_reset_mid();
      int w, b2;
      @(posedge clk); #1;
      rr[2] = 1'b0;
      send_beat(3, 8'h24, 1'b0, w);
      send_beat(1, 8'hD0, 1'b0, w);
      send_beat(1, 8'hD1, 1'b0, w);
      sv[1] = 1'b1; sd[1] = 8'hD2;
      @(negedge clk);
      checks++;
      if (bvo[1] !== 1'b1 || rv[2] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_pre: bvo1=%b rv2=%b expected 1,1", bvo[1], rv[2]);
      end
      b2 = rcnt[2];
      rst_n = 1'b0;
      #1;
      checks++;
      if (rv[2] !== 1'b0 || bvo[1] !== 1'b0 || g_node[1].u_node.state_q !== ST_IDLE || bro[2] !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_now: rv2=%b bvo1=%b state=%0d bro2=%b expected 0,0,IDLE,1",
                  rv[2], bvo[1], g_node[1].u_node.state_q, bro[2]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      rr[2] = 1'b1;
      repeat (4) @(negedge clk);
      checks++;
      if (bvo[1] !== 1'b0 || rv[2] !== 1'b0 || rcnt[2] - b2 !== 0) begin
         errors++;
         $display("FAIL rstmid_after: bvo1=%b rv2=%b beats=%0d expected 0,0,0", bvo[1], rv[2], rcnt[2] - b2);
      end
      sv[1] = 1'b0;
   endtask

   task automatic test_gap();
      int w, b2;
      @(posedge clk); #1;
      b2 = rcnt[2];
      send_beat(3, 8'h24, 1'b0, w);
      send_beat(1, 8'hE0, 1'b0, w);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (bvo[1] !== 1'b0 || g_node[1].u_node.state_q !== ST_OWN) begin
            errors++;
            $display("FAIL gap_cycle%0d: bvo1=%b state=%0d expected 0,OWN", k, bvo[1], g_node[1].u_node.state_q);
         end
      end
      @(posedge clk); #1;
      send_beat(1, 8'hE1, 1'b1, w);
      repeat (4) @(negedge clk);
      checks++;
      if (!all_idle() || rcnt[2] - b2 !== 3 || log2.size() != b2 + 3 || log2[b2 + 2] !== {1'b1, 8'hE1}) begin
         errors++;
         $display("FAIL gap_done: idle=%b beats=%0d expected 1,3 ending E1 with last", all_idle(), rcnt[2] - b2);
      end
   endtask

`ifdef DATA_BUS_NODE_PARITY_EN
   task automatic test_parity();
      int w, b2;
      @(posedge clk); #1;
      b2 = rcnt[2];
      send_beat(3, 8'h24, 1'b0, w);
      send_beat(1, 8'h31, 1'b0, w);
      @(negedge clk);
      checks++;
      if (pe[2] !== 1'b0) begin
         errors++;
         $display("FAIL par_clean: par_err2=%b expected 0", pe[2]);
      end
      @(posedge clk); #1;
      par_flip = 1'b1;
      send_beat(1, 8'h32, 1'b0, w);
      par_flip = 1'b0;
      @(negedge clk);
      checks++;
      if (pe[2] !== 1'b1) begin
         errors++;
         $display("FAIL par_set: par_err2=%b expected 1", pe[2]);
      end
      @(posedge clk); #1;
      send_beat(1, 8'h33, 1'b1, w);
      repeat (4) @(negedge clk);
      checks++;
      if (pe[2] !== 1'b1 || rcnt[2] - b2 !== 4 || log2[b2 + 2] !== {1'b0, 8'h32}) begin
         errors++;
         $display("FAIL par_sticky: par_err2=%b beats=%0d expected 1,4", pe[2], rcnt[2] - b2);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks++;
      if (pe[2] !== 1'b0) begin
         errors++;
         $display("FAIL par_reset: par_err2=%b expected 0", pe[2]);
      end
   endtask
`endif

   initial begin
      sv = '0; sl = '0; sd = '0; rr = '1;
      test_reset();
      test_basic();
      test_backpressure();
      test_hdr_only();
      test_reset_mid();
      test_gap();
`ifdef DATA_BUS_NODE_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
